aes128_word_loader: RTL and testbench
=====================================

Name: aes128_word_loader

Overview:
- Front-end stage feeding aes128_encrypt_top.
- Accepts a 32-bit word stream over a valid/ready handshake and assembles the 128-bit key and plaintext from it.
- Drives key_0..3 and plain_text_0..3 to the core and holds them stable for CORE_LATENCY cycles.
- Then captures cipher_text_0..3 into a 128-bit result register, offered downstream with valid/ready.

Parameters:
CORE_LATENCY, 32, cycles the core inputs are held stable before cipher_text is sampled (must be >= 1)
CNT_W, 16, width of the settle counter (must satisfy CORE_LATENCY < 2**CNT_W)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_data  input  32  input word
in_is_key  input  1  1 = in_data is a key word, 0 = plaintext word
in_valid  input  1  in_data/in_is_key valid
in_ready  output  1  word accepted on an edge where in_valid && in_ready
key_0..key_3  output  32 each  key words to core (key_0 = bits 31:0)
plain_text_0..plain_text_3  output  32 each  plaintext words to core
cipher_text_0..cipher_text_3  input  32 each  core result
ct_out  output  128  captured ciphertext, ct_out[31:0] = cipher_text_0
ct_valid  output  1  ct_out valid
ct_ready  input  1  downstream accepts ct_out
busy  output  1  high in SETTLE and OUT

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high.
- Reset values: state LOAD; all key_*, plain_text_*, ct_out = 0; ct_valid = 0; busy = 0; key_loaded = 0; key_cnt = pt_cnt = 0; settle counter = 0.
- Word order: the first word of each group goes to index 0, then 1, 2, 3.
- State LOAD:
  - in_ready = 1, except when pt_cnt == 4 && !in_is_key; in that case in_ready = 0. This is a combinational path from in_is_key.
  - Accepted key word: writes key_[key_cnt]; key_cnt increments and wraps 3 -> 0.
  - key_loaded clears when key word 0 is accepted and sets when key word 3 is accepted.
  - Accepted plaintext word: writes plain_text_[pt_cnt]; pt_cnt increments, saturating at 4.
- Launch: on the edge where pt_cnt == 4 and key_loaded == 1 are both true after the update:
  - go to SETTLE;
  - load the counter with CORE_LATENCY;
  - the same edge may be the one that accepted the final key or plaintext word.
- State SETTLE:
  - in_ready = 0; key_* and plain_text_* are frozen.
  - The counter decrements each cycle.
  - On the edge where the counter == 0: sample cipher_text_0..3 into ct_out, set ct_valid = 1, go to OUT.
  - Net result: ct_valid rises CORE_LATENCY+1 edges after the launch edge.
- State OUT:
  - in_ready = 0; ct_out is held.
  - On an edge with ct_valid && ct_ready: ct_valid = 0, pt_cnt = 0, go to LOAD.
  - The key and key_loaded are retained, so subsequent blocks need only 4 plaintext words.
- Key rewrite: allowed in LOAD at any pt_cnt. A partial key (key_loaded = 0) blocks launch until the 4th key word arrives.
- ct_ready asserted outside OUT has no effect. in_valid outside LOAD is ignored (no accept).
- Reset asserted mid-SETTLE or mid-OUT: immediate return to reset values, key discarded; no ct_valid pulse.

Optional Feature:
- Macro AES_LOADER_BYTESWAP_EN.
- Defined: every accepted in_data word is byte-reversed before storage (in_data[7:0] goes to word[31:24], and so on). Each 32-bit lane of ct_out is byte-reversed at capture.
- Undefined: words are stored and captured unchanged.
- Ports and timing are identical in both builds.

Test Plan:
- Basic block, macro undefined, CORE_LATENCY=32, bench core stub cipher_text_i = key_i ^ plain_text_i. Stimulus: key words 04030201, 08070605, 0C0B0A09, 100F0E0D, then plaintext words 6f6e6f43, 6f4e2072, 206e616c, 54494d47. Required: ct_valid rises exactly 33 edges after the 8th accept, with ct_out = 4446434a2c656b65674926776b6d6d42.
- Key reuse: after the first block completes, send plaintext only (word 3 = 52494d47). Required: launch without new key words, ct_out[127:96] = 4246434a.
- Backpressure: hold ct_ready = 0 for 10 cycles in OUT. Required: ct_valid and ct_out stable, in_ready = 0; one accept on the ct_ready edge, then in_ready = 1 the next cycle.
- Plaintext before key: send 4 plaintext words, then key words with a gap. Required: pt_cnt holds at 4, in_ready = 0 for in_is_key = 0 and 1 for in_is_key = 1; launch on the 4th key word edge.
- Reset mid-SETTLE: assert reset at counter == 10. Required: ct_valid never rises; all outputs 0 and key_loaded = 0 immediately; a fresh 8-word sequence then produces the same result as the basic-block case.
- With AES_LOADER_BYTESWAP_EN, using the basic-block words: key_0 = 01020304, and ct_out is byte-reversed per lane relative to the XOR of the stored key and plaintext words.

Source files
------------

// File: rtl/aes128_word_loader.sv
// aes128_word_loader: front-end for aes128_encrypt_top.
// Assembles a 128-bit key and plaintext from a 32-bit valid/ready word
// stream, holds them stable on the core inputs for CORE_LATENCY cycles,
// then captures the core's ciphertext into a result register offered
// downstream with valid/ready. The key is retained between blocks.
// Optional build macro AES_LOADER_BYTESWAP_EN: byte-reverses every stored
// input word and every 32-bit lane of the captured ciphertext.
module aes128_word_loader #(
  parameter int CORE_LATENCY = 32,
  parameter int CNT_W        = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  in_data,
  input  logic         in_is_key,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [31:0]  key_0,
  output logic [31:0]  key_1,
  output logic [31:0]  key_2,
  output logic [31:0]  key_3,
  output logic [31:0]  plain_text_0,
  output logic [31:0]  plain_text_1,
  output logic [31:0]  plain_text_2,
  output logic [31:0]  plain_text_3,
  input  logic [31:0]  cipher_text_0,
  input  logic [31:0]  cipher_text_1,
  input  logic [31:0]  cipher_text_2,
  input  logic [31:0]  cipher_text_3,
  output logic [127:0] ct_out,
  output logic         ct_valid,
  input  logic         ct_ready,
  output logic         busy
);

  typedef enum logic [1:0] {LOAD, SETTLE, OUT} state_t;

  localparam logic [CNT_W-1:0] SETTLE_START = CNT_W'(CORE_LATENCY);

  // Lane ordering applied to stored input words and captured result lanes.
  function automatic logic [31:0] lane_order(input logic [31:0] w);
`ifdef AES_LOADER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      key_r [4];
  logic [31:0]      pt_r  [4];
  logic [1:0]       key_cnt;
  logic [2:0]       pt_cnt;
  logic [2:0]       pt_cnt_nxt;
  logic             key_loaded;
  logic             key_loaded_nxt;
  logic [CNT_W-1:0] settle_cnt;
  logic             accept;
  logic             key_acc;
  logic             pt_acc;
  logic             launch;
  logic             capture;
  logic             release_ct;

  // A full plaintext group blocks further plaintext but still lets a key
  // rewrite through, hence the combinational dependence on in_is_key.
  assign in_ready = (state == LOAD) && !((pt_cnt == 3'd4) && !in_is_key);
  assign accept   = in_valid && in_ready;
  assign key_acc  = accept && in_is_key;
  assign pt_acc   = accept && !in_is_key;
  assign busy     = (state != LOAD);

  assign key_0 = key_r[0];
  assign key_1 = key_r[1];
  assign key_2 = key_r[2];
  assign key_3 = key_r[3];
  assign plain_text_0 = pt_r[0];
  assign plain_text_1 = pt_r[1];
  assign plain_text_2 = pt_r[2];
  assign plain_text_3 = pt_r[3];

  // Post-update counter/flag values, so launch can fire on the final accept edge.
  always_comb begin
    key_loaded_nxt = key_loaded;
    pt_cnt_nxt     = pt_cnt;
    if (key_acc) begin
      if (key_cnt == 2'd0) begin
        key_loaded_nxt = 1'b0;
      end else if (key_cnt == 2'd3) begin
        key_loaded_nxt = 1'b1;
      end
    end
    if (pt_acc) begin
      pt_cnt_nxt = pt_cnt + 3'd1;
    end
  end

  // Next-state decode and the single-cycle launch/capture/release strobes.
  always_comb begin
    state_nxt  = state;
    launch     = 1'b0;
    capture    = 1'b0;
    release_ct = 1'b0;
    case (state)
      LOAD: begin
        if ((pt_cnt_nxt == 3'd4) && key_loaded_nxt) begin
          launch    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (ct_valid && ct_ready) begin
          release_ct = 1'b1;
          state_nxt  = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Key/plaintext word storage; only LOAD accepts, so SETTLE and OUT freeze them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        key_r[i] <= '0;
        pt_r[i]  <= '0;
      end
      key_cnt    <= '0;
      pt_cnt     <= '0;
      key_loaded <= 1'b0;
    end else begin
      if (key_acc) begin
        key_r[key_cnt] <= lane_order(in_data);
      end
      if (pt_acc) begin
        pt_r[pt_cnt[1:0]] <= lane_order(in_data);
      end
      if (key_acc) begin
        key_cnt <= key_cnt + 2'd1;
      end
      key_loaded <= key_loaded_nxt;
      pt_cnt     <= release_ct ? 3'd0 : pt_cnt_nxt;
    end
  end

  // Settle counter: loaded at launch, counts down to zero while the core works.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt <= '0;
    end else if (launch) begin
      settle_cnt <= SETTLE_START;
    end else if ((state == SETTLE) && (settle_cnt != '0)) begin
      settle_cnt <= settle_cnt - 1'b1;
    end
  end

  // Result register: captured once per block and held until downstream takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ct_out   <= '0;
      ct_valid <= 1'b0;
    end else if (capture) begin
      ct_out   <= {lane_order(cipher_text_3), lane_order(cipher_text_2),
                   lane_order(cipher_text_1), lane_order(cipher_text_0)};
      ct_valid <= 1'b1;
    end else if (release_ct) begin
      ct_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes128_word_loader.sv
// tb_aes128_word_loader: scoreboard bench for aes128_word_loader with an
// XOR core stub (cipher_text_i = key_i ^ plain_text_i).
module tb_aes128_word_loader;

  localparam int CORE_LATENCY = 32;
  localparam int WAIT_LIMIT   = CORE_LATENCY + 20;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  in_data;
  logic         in_is_key;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  key_0, key_1, key_2, key_3;
  logic [31:0]  plain_text_0, plain_text_1, plain_text_2, plain_text_3;
  logic [31:0]  cipher_text_0, cipher_text_1, cipher_text_2, cipher_text_3;
  logic [127:0] ct_out;
  logic         ct_valid;
  logic         ct_ready;
  logic         busy;

  always #5 clk = ~clk;

  assign cipher_text_0 = key_0 ^ plain_text_0;
  assign cipher_text_1 = key_1 ^ plain_text_1;
  assign cipher_text_2 = key_2 ^ plain_text_2;
  assign cipher_text_3 = key_3 ^ plain_text_3;

  aes128_word_loader #(.CORE_LATENCY(CORE_LATENCY), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_is_key(in_is_key), .in_valid(in_valid), .in_ready(in_ready),
    .key_0(key_0), .key_1(key_1), .key_2(key_2), .key_3(key_3),
    .plain_text_0(plain_text_0), .plain_text_1(plain_text_1),
    .plain_text_2(plain_text_2), .plain_text_3(plain_text_3),
    .cipher_text_0(cipher_text_0), .cipher_text_1(cipher_text_1),
    .cipher_text_2(cipher_text_2), .cipher_text_3(cipher_text_3),
    .ct_out(ct_out), .ct_valid(ct_valid), .ct_ready(ct_ready), .busy(busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Count rising edges so the monitor can measure result latency.
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] ct;
    int           due;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state: what the loader should hold, by the rules.
  logic [31:0] m_key [4];
  logic [31:0] m_pt  [4];
  int          m_kc;
  int          m_pc;
  bit          m_kl;
  bit          m_busy;

  logic [31:0] basic_key [4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
  logic [31:0] basic_pt  [4] = '{32'h6f6e6f43, 32'h6f4e2072, 32'h206e616c, 32'h54494d47};

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] model_store(input logic [31:0] w);
`ifdef AES_LOADER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [127:0] model_result();
    logic [127:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*32 +: 32] = model_store(m_key[i] ^ m_pt[i]);
    end
    return r;
  endfunction

  function automatic bit model_ready(input bit is_key);
    return !m_busy && !(m_pc == 4 && !is_key);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_key[i] = '0;
      m_pt[i]  = '0;
    end
    m_kc = 0; m_pc = 0; m_kl = 0; m_busy = 0;
  endtask

  task automatic model_accept(input logic [31:0] d, input bit is_key, input int due);
    exp_t e;
    if (is_key) begin
      m_key[m_kc] = model_store(d);
      if (m_kc == 0) m_kl = 0;
      if (m_kc == 3) m_kl = 1;
      m_kc = (m_kc + 1) % 4;
    end else if (m_pc < 4) begin
      m_pt[m_pc] = model_store(d);
      m_pc++;
    end
    if (!m_busy && m_pc == 4 && m_kl) begin
      e.ct  = model_result();
      e.due = due;
      sb_q.push_back(e);
      m_busy = 1;
    end
  endtask

  // Offer one word for one cycle; the model decides whether it must be taken.
  task automatic apply_stimulus(input logic [31:0] d, input bit is_key);
    bit rdy;
    int due;
    in_data   = d;
    in_is_key = is_key;
    in_valid  = 1'b1;
    @(negedge clk);
    rdy = model_ready(is_key);
    check_output("in_ready", in_ready, rdy);
    check_output("busy", busy, m_busy);
    due = cyc + CORE_LATENCY + 2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (rdy) model_accept(d, is_key, due);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_core_inputs(input string name);
    check_output(name, {key_3, key_2, key_1, key_0}, {m_key[3], m_key[2], m_key[1], m_key[0]});
    check_output(name, {plain_text_3, plain_text_2, plain_text_1, plain_text_0},
                 {m_pt[3], m_pt[2], m_pt[1], m_pt[0]});
  endtask

  // Wait for the result, optionally backpressure it, then complete the handshake.
  task automatic wait_result(input int hold, input bit early);
    int n;
    ct_ready = early;
    n = 0;
    @(negedge clk);
    while (!ct_valid && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (!ct_valid) begin
      check_output("ct_valid_timeout", ct_valid, 1'b1);
      sb_q.delete();
    end else if (!early) begin
      repeat (hold) @(negedge clk);
      @(posedge clk);
      #1;
      ct_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    ct_ready = 1'b0;
    m_busy   = 0;
    m_pc     = 0;
    check_output("in_ready_after_release", in_ready, model_ready(in_is_key));
    check_output("ct_valid_after_release", ct_valid, 1'b0);
    check_output("busy_after_release", busy, 1'b0);
  endtask

  task automatic check_reset_values(input string name);
    check_output({name, "_ct_valid"}, ct_valid, 1'b0);
    check_output({name, "_busy"}, busy, 1'b0);
    check_output({name, "_ct_out"}, ct_out, 128'h0);
    check_output({name, "_key"}, {key_3, key_2, key_1, key_0}, 128'h0);
    check_output({name, "_pt"}, {plain_text_3, plain_text_2, plain_text_1, plain_text_0}, 128'h0);
    check_output({name, "_in_ready"}, in_ready, 1'b1);
  endtask

  // Monitor: pops the scoreboard on each result, checks value, latency and hold.
  bit prev_valid = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (ct_valid) begin
        if (sb_q.size() == 0) begin
          if (!prev_valid) check_output("ct_unexpected", ct_valid, 1'b0);
        end else begin
          if (!prev_valid) begin
            check_output("ct_latency", cyc, sb_q[0].due);
            check_output("ct_out", ct_out, sb_q[0].ct);
          end else begin
            check_output("ct_out_hold", ct_out, sb_q[0].ct);
          end
          check_output("in_ready_in_out", in_ready, 1'b0);
          check_output("busy_in_out", busy, 1'b1);
          if (ct_ready) void'(sb_q.pop_front());
        end
      end
      prev_valid = ct_valid;
    end
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bit seen;
    int guard;
    reset     = 1'b1;
    in_data   = '0;
    in_is_key = 1'b0;
    in_valid  = 1'b0;
    ct_ready  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_state");
    reset = 1'b0;
    idle(1);

    $display("[TB] basic block");
    for (int i = 0; i < 4; i++) apply_stimulus(basic_key[i], 1'b1);
    for (int i = 0; i < 4; i++) apply_stimulus(basic_pt[i], 1'b0);
    check_core_inputs("core_inputs_basic");
    wait_result(0, 1'b0);

    $display("[TB] key reuse with backpressure");
    for (int i = 0; i < 3; i++) apply_stimulus(basic_pt[i], 1'b0);
    apply_stimulus(32'h52494d47, 1'b0);
    apply_stimulus($urandom, 1'b1);
    apply_stimulus($urandom, 1'b0);
    check_core_inputs("core_inputs_frozen");
    wait_result(10, 1'b0);

    $display("[TB] plaintext before key");
    apply_stimulus($urandom, 1'b1);
    for (int i = 0; i < 4; i++) apply_stimulus($urandom, 1'b0);
    apply_stimulus($urandom, 1'b0);
    for (int i = 1; i < 4; i++) begin
      idle(2);
      apply_stimulus($urandom, 1'b1);
    end
    wait_result(0, 1'b1);

    $display("[TB] reset during settle");
    for (int i = 0; i < 4; i++) apply_stimulus(basic_key[i], 1'b1);
    for (int i = 0; i < 4; i++) apply_stimulus(basic_pt[i], 1'b0);
    repeat (CORE_LATENCY - 10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_values("reset_mid_settle");
    sb_q.delete();
    model_reset();
    idle(2);
    reset = 1'b0;
    seen = 1'b0;
    repeat (CORE_LATENCY + 4) begin
      @(negedge clk);
      if (ct_valid) seen = 1'b1;
    end
    idle(1);
    check_output("no_ct_after_reset", seen, 1'b0);
    for (int i = 0; i < 4; i++) apply_stimulus(basic_pt[i], 1'b0);
    for (int i = 0; i < 4; i++) apply_stimulus(basic_key[i], 1'b1);
    wait_result(3, 1'b0);

    $display("[TB] randomized blocks");
    for (int b = 0; b < 16; b++) begin
      guard = 0;
      while (!m_busy && guard < 40) begin
        apply_stimulus($urandom, ($urandom_range(0, 3) == 0));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        guard++;
      end
      if (m_busy) begin
        if ($urandom_range(0, 1) == 1) apply_stimulus($urandom, ($urandom_range(0, 1) == 1));
        wait_result($urandom_range(0, 4), ($urandom_range(0, 1) == 1));
      end
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
